dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the 8-word data memory.
- Port 0 is the CPU load/store path; port 1 is the DMA/debug loader.
- One access is in flight at a time. The arbiter latches the winning request, drives the memory's address/write_data/MemRead/MemWrite for exactly one cycle, and returns a registered response with a valid pulse.
- Memory read is combinational; memory write commits on the clk rising edge.

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_if.sv | 28 ++
 rtl/dmem_arbiter_rr_arb2.sv | 51 +++++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter:
// FSM state encoding, requester owner ids and the default memory depth.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Port 0 is the CPU load/store path, port 1 the DMA/debug loader.
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    localparam int DEPTH_DEFAULT = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one arbiter port.
// Handshake: the requester raises req with we/addr/wdata stable and holds them
// until gnt pulses for one cycle; after gnt it may drop or change them freely.
// Exactly one cycle after gnt, rvalid pulses for one cycle with rdata/err
// valid only while rvalid is high (reads and writes both get a response).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input arbiter. Default build is round-robin on a last_owner bit that
// starts at OWNER_DMA so port 0 wins the first tie. Defining
// DMEM_ARB_FIXED_PRI_EN switches to fixed priority (port 0 always wins) and
// removes the last_owner register.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic update,   // a grant is being taken this cycle
    output logic any_req,
    output logic winner
);

    assign any_req = req0 | req1;

`ifdef DMEM_ARB_FIXED_PRI_EN
    logic unused_fixed;
    assign unused_fixed = clk ^ rst_n ^ update;

    // Port 0 wins whenever it asks.
    always_comb begin
        winner = req0 ? OWNER_CPU : OWNER_DMA;
    end
`else
    logic last_owner;

    // Remember who was granted last so a tie goes to the other port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWNER_DMA;
        end else if (update) begin
            last_owner <= winner;
        end
    end

    // Tie goes to the port that is not last_owner; a sole requester wins.
    always_comb begin
        if (req0 && req1) begin
            winner = ~last_owner;
        end else if (req0) begin
            winner = OWNER_CPU;
        end else begin
            winner = OWNER_DMA;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the 8-word data memory.
// One access in flight: IDLE picks a winner, ACCESS drives the memory for one
// cycle (winner's gnt high), RESP returns the registered response with an
// rvalid pulse to the owner. Optional fixed priority via DMEM_ARB_FIXED_PRI_EN
// (handled inside rr_arb2).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     r0,
    dmem_arbiter_if.slave     r1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output state_t            dbg_state
);

    // One extra bit so DEPTH never truncates in the range compare.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic              owner;
    logic              we_q;
    logic              in_range_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        gnt_q;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [1:0]        err_q;

    logic              any_req;
    logic              winner;
    logic              arb_update;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;
    logic [DATA_W-1:0] rd_val;

    assign arb_update = (state == IDLE) && any_req;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (r0.req),
        .req1    (r1.req),
        .update  (arb_update),
        .any_req (any_req),
        .winner  (winner)
    );

    // Steer the winning port's request fields and classify its address.
    always_comb begin
        sel_we       = (winner == OWNER_DMA) ? r1.we    : r0.we;
        sel_addr     = (winner == OWNER_DMA) ? r1.addr  : r0.addr;
        sel_wdata    = (winner == OWNER_DMA) ? r1.wdata : r0.wdata;
        sel_in_range = ({1'b0, sel_addr} < DEPTH_L);
        rd_val       = (in_range_q && !we_q) ? mem_read_data : '0;
    end

    // Sequencer: all outputs are registered so the memory strobes are clean
    // one-cycle pulses and an async reset clears them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWNER_CPU;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            err_q      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ACCESS;
                        owner      <= winner;
                        we_q       <= sel_we;
                        in_range_q <= sel_in_range;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        gnt_q      <= (winner == OWNER_DMA) ? 2'b10 : 2'b01;
                    end
                end
                ACCESS: begin
                    // Memory write commits on this same edge; capture read data.
                    state    <= RESP;
                    gnt_q    <= 2'b00;
                    addr_q   <= '0;
                    wdata_q  <= '0;
                    rvalid_q <= (owner == OWNER_DMA) ? 2'b10 : 2'b01;
                    rdata0_q <= (owner == OWNER_CPU) ? rd_val : '0;
                    rdata1_q <= (owner == OWNER_DMA) ? rd_val : '0;
                    err_q    <= (owner == OWNER_DMA) ? {!in_range_q, 1'b0}
                                                     : {1'b0, !in_range_q};
                end
                RESP: begin
                    state    <= IDLE;
                    we_q     <= 1'b0;
                    rvalid_q <= 2'b00;
                    rdata0_q <= '0;
                    rdata1_q <= '0;
                    err_q    <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory strobes are only live during ACCESS; address/data are zero otherwise.
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_read       = (state == ACCESS) && !we_q;
    assign mem_write      = (state == ACCESS) && we_q && in_range_q;

    assign r0.gnt    = gnt_q[0];
    assign r1.gnt    = gnt_q[1];
    assign r0.rvalid = rvalid_q[0];
    assign r1.rvalid = rvalid_q[1];
    assign r0.rdata  = rdata0_q;
    assign r1.rdata  = rdata1_q;
    assign r0.err    = err_q[0];
    assign r1.err    = err_q[1];

    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level timeline model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if r0_if ();
    dmem_arbiter_if r1_if ();

    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_read;
    logic        mem_write;
    state_t      dbg_state;

    dmem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .r0             (r0_if),
        .r1             (r1_if),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .dbg_state      (dbg_state)
    );

    // 8-word data memory: combinational read, write on rising edge.
    logic [31:0] mem [8] = '{32'h0, 32'd28, 32'd7, 32'h11, 32'h3FF, 32'h55, 32'h66, 32'h77};
    assign mem_read_data = mem[mem_address[2:0]];
    always @(posedge clk) begin
        if (mem_write && mem_address < 32'd8) mem[mem_address[2:0]] <= mem_write_data;
    end

    // Reference memory contents, updated when a modelled write completes.
    logic [31:0] ref_mem [8] = '{32'h0, 32'd28, 32'd7, 32'h11, 32'h3FF, 32'h55, 32'h66, 32'h77};

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int next_arb = 1 << 30;

    // The one modelled transaction in flight.
    bit          tx_valid = 1'b0;
    bit          tx_owner;
    bit          tx_we;
    bit          tx_err;
    logic [31:0] tx_addr;
    logic [31:0] tx_wdata;
    logic [31:0] tx_rdata;
    int          tx_gnt_cyc;
    bit          m_last = 1'b1;
    bit          drop_on_gnt [2] = '{1'b1, 1'b1};
    int          gnt_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic issue(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 1'b0) begin
            r0_if.req = 1'b1; r0_if.we = we; r0_if.addr = addr; r0_if.wdata = wdata;
        end else begin
            r1_if.req = 1'b1; r1_if.we = we; r1_if.addr = addr; r1_if.wdata = wdata;
        end
    endtask

    task automatic drop(input bit p);
        if (p == 1'b0) r0_if.req = 1'b0;
        else r1_if.req = 1'b0;
    endtask

    // Decide what the arbiter must do at the coming edge from the current requests.
    task automatic arbitrate();
        bit w;
        if (rst_n && (cyc + 1 >= next_arb) && (r0_if.req || r1_if.req)) begin
`ifdef DMEM_ARB_FIXED_PRI_EN
            w = r0_if.req ? 1'b0 : 1'b1;
`else
            if (r0_if.req && r1_if.req) w = !m_last;
            else w = r0_if.req ? 1'b0 : 1'b1;
`endif
            m_last     = w;
            tx_valid   = 1'b1;
            tx_owner   = w;
            tx_we      = w ? r1_if.we : r0_if.we;
            tx_addr    = w ? r1_if.addr : r0_if.addr;
            tx_wdata   = w ? r1_if.wdata : r0_if.wdata;
            tx_err     = (tx_addr >= 32'd8);
            tx_rdata   = (!tx_err && !tx_we) ? ref_mem[tx_addr[2:0]] : 32'd0;
            tx_gnt_cyc = cyc + 1;
            next_arb   = cyc + 4;
        end
    endtask

    // Compare every DUT output for the current cycle against the timeline.
    task automatic check_cycle();
        bit g;
        bit r;
        g = tx_valid && (cyc == tx_gnt_cyc);
        r = tx_valid && (cyc == tx_gnt_cyc + 1);
        chk("r0_gnt", 32'(r0_if.gnt), 32'(g && !tx_owner));
        chk("r1_gnt", 32'(r1_if.gnt), 32'(g && tx_owner));
        chk("mem_read", 32'(mem_read), 32'(g && !tx_we));
        chk("mem_write", 32'(mem_write), 32'(g && tx_we && !tx_err));
        chk("mem_address", mem_address, g ? tx_addr : 32'd0);
        chk("mem_write_data", mem_write_data, g ? tx_wdata : 32'd0);
        chk("r0_rvalid", 32'(r0_if.rvalid), 32'(r && !tx_owner));
        chk("r1_rvalid", 32'(r1_if.rvalid), 32'(r && tx_owner));
        chk("r0_rdata", r0_if.rdata, (r && !tx_owner) ? tx_rdata : 32'd0);
        chk("r1_rdata", r1_if.rdata, (r && tx_owner) ? tx_rdata : 32'd0);
        chk("r0_err", 32'(r0_if.err), 32'(r && !tx_owner && tx_err));
        chk("r1_err", 32'(r1_if.err), 32'(r && tx_owner && tx_err));
        if (r0_if.gnt) gnt_log.push_back(0);
        if (r1_if.gnt) gnt_log.push_back(1);
        if (g && drop_on_gnt[tx_owner]) drop(tx_owner);
        if (r) begin
            if (tx_we && !tx_err) ref_mem[tx_addr[2:0]] = tx_wdata;
            tx_valid = 1'b0;
        end
    endtask

    task automatic step();
        arbitrate();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_cycle();
    endtask

    initial begin
        int exp_order [4];
        r0_if.req = 1'b0; r0_if.we = 1'b0; r0_if.addr = '0; r0_if.wdata = '0;
        r1_if.req = 1'b0; r1_if.we = 1'b0; r1_if.addr = '0; r1_if.wdata = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_cycle();
        chk("reset_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        next_arb = cyc + 1;

        // Both ports hold read requests of word 2.
        drop_on_gnt[0] = 1'b0;
        drop_on_gnt[1] = 1'b0;
        gnt_log.delete();
        issue(0, 1'b0, 32'd2, 32'd0);
        issue(1, 1'b0, 32'd2, 32'd0);
        repeat (12) step();
        drop(0);
        drop(1);
        drop_on_gnt[0] = 1'b1;
        drop_on_gnt[1] = 1'b1;
`ifdef DMEM_ARB_FIXED_PRI_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        chk("tie_grant_count", gnt_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tie_grant_%0d", i), (i < gnt_log.size()) ? gnt_log[i] : -1, exp_order[i]);
        end

        // r0 reads word 1.
        issue(0, 1'b0, 32'd1, 32'd0);
        repeat (3) step();

        // r1 writes word 3, then r0 reads it back.
        issue(1, 1'b1, 32'd3, 32'hA5A5);
        repeat (3) step();
        issue(0, 1'b0, 32'd3, 32'd0);
        repeat (3) step();
        chk("word3_written", mem[3], 32'hA5A5);

        // Out-of-range write.
        issue(0, 1'b1, 32'd9, 32'hFFFF);
        repeat (3) step();

        // r1 write to word 4 killed by a reset during ACCESS.
        issue(1, 1'b1, 32'd4, 32'hDEAD);
        step();
        #2 rst_n = 1'b0;
        tx_valid = 1'b0;
        m_last = 1'b1;
        next_arb = 1 << 30;
        drop(0);
        drop(1);
        #1;
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_r1_gnt", 32'(r1_if.gnt), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_cycle();
        rst_n = 1'b1;
        next_arb = cyc + 1;
        repeat (2) step();
        chk("word4_kept", mem[4], 32'h3FF);
        chk("post_rst_state", 32'(dbg_state), 32'(IDLE));

        // Random traffic, including out-of-range addresses.
        for (int k = 0; k < 300; k++) begin
            if (!r0_if.req && $urandom_range(0, 2) == 0)
                issue(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 11)), $urandom);
            if (!r1_if.req && $urandom_range(0, 2) == 0)
                issue(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 11)), $urandom);
            step();
        end
        drop(0);
        drop(1);
        repeat (4) step();

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("final_word_%0d", i), mem[i], ref_mem[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
